// File: rtl/noc_flit_injector_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : noc_flit_injector_if                                   |
// | Description : Descriptor, payload and router-FIFO signals of the     |
// |               flit injector, grouped with master/slave views.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface noc_flit_injector_if #(
   parameter int FLIT_WIDTH = 32
);
   logic                  pkt_valid;
   logic                  pkt_ready;
   logic [3:0]            pkt_dest;
   logic [7:0]            pkt_len;
   logic                  pl_valid;
   logic                  pl_ready;
   logic [29:0]           pl_data;
   logic                  fifo_full;
   logic                  wr_en;
   logic [FLIT_WIDTH-1:0] data_out;
   logic                  busy;
   logic                  pkt_sent;
   logic [13:0]           seq_num;

   // master is the injector itself; slave is whatever feeds and drains it
   modport master (
      input  pkt_valid, pkt_dest, pkt_len, pl_valid, pl_data, fifo_full,
      output pkt_ready, pl_ready, wr_en, data_out, busy, pkt_sent, seq_num
   );

   modport slave (
      output pkt_valid, pkt_dest, pkt_len, pl_valid, pl_data, fifo_full,
      input  pkt_ready, pl_ready, wr_en, data_out, busy, pkt_sent, seq_num
   );
endinterface
`default_nettype wire

// File: rtl/noc_flit_injector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : noc_flit_injector                                      |
// | Description : Serialises packet descriptors plus payload words into  |
// |               head/body/tail flits for one router input FIFO.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module noc_flit_injector #(
   parameter int FLIT_WIDTH = 32,
   parameter int NODE_ID    = 0,
   parameter int MAX_LEN    = 16
) (
   input  wire                  clk,
   input  wire                  reset,
   noc_flit_injector_if.master  bus
);

   localparam logic [3:0] c_node_id = 4'(NODE_ID);
   localparam logic [7:0] c_max_len = 8'(MAX_LEN);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEAD    = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_dest;
   logic [7:0]            r_len;
   logic [7:0]            r_remaining;
   logic [13:0]           r_seq;
   logic                  r_pkt_sent;

   logic                  w_pkt_ready;
   logic                  w_pl_ready;
   logic                  w_wr_en;
   logic [FLIT_WIDTH-1:0] w_data_out;
   logic [FLIT_WIDTH-1:0] w_head_flit;
   logic [7:0]            w_len_clamped;
   logic                  w_accept;
   logic                  w_last_write;

   assign w_len_clamped = (bus.pkt_len > c_max_len) ? c_max_len : bus.pkt_len;

   // A zero-length packet goes out as a single self-contained head flit
   assign w_head_flit = {((r_len == 8'd0) ? 2'b11 : 2'b01),
                         r_dest, c_node_id, r_len, r_seq};

   always_comb begin
      w_next      = r_state;
      w_pkt_ready = 1'b0;
      w_pl_ready  = 1'b0;
      w_wr_en     = 1'b0;
      w_data_out  = '0;
      case (r_state)
         S_IDLE: begin
            w_pkt_ready = 1'b1;
            if (bus.pkt_valid) begin
               w_next = S_HEAD;
            end
         end
         S_HEAD: begin
            w_data_out = w_head_flit;
            w_wr_en    = ~bus.fifo_full;
            if (w_wr_en) begin
               w_next = (r_len == 8'd0) ? S_IDLE : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            w_pl_ready = ~bus.fifo_full;
            w_wr_en    = bus.pl_valid & ~bus.fifo_full;
            w_data_out = {((r_remaining == 8'd1) ? 2'b10 : 2'b00), bus.pl_data};
            if (w_wr_en && (r_remaining == 8'd1)) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      // Outputs are forced quiet for the whole time reset is held
      if (reset) begin
         w_next      = S_IDLE;
         w_pkt_ready = 1'b0;
         w_pl_ready  = 1'b0;
         w_wr_en     = 1'b0;
         w_data_out  = '0;
      end
   end

   assign w_accept     = w_pkt_ready & bus.pkt_valid;
   assign w_last_write = w_wr_en &
                         (((r_state == S_HEAD) && (r_len == 8'd0)) ||
                          ((r_state == S_PAYLOAD) && (r_remaining == 8'd1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_dest      <= 4'd0;
         r_len       <= 8'd0;
         r_remaining <= 8'd0;
         r_seq       <= 14'd0;
         r_pkt_sent  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_pkt_sent <= w_last_write;
         if (w_accept) begin
            r_dest <= bus.pkt_dest;
            r_len  <= w_len_clamped;
         end
         if ((r_state == S_HEAD) && w_wr_en) begin
            r_seq       <= r_seq + 14'd1;
            r_remaining <= r_len;
         end
         if ((r_state == S_PAYLOAD) && w_wr_en) begin
            r_remaining <= r_remaining - 8'd1;
         end
      end
   end

   assign bus.pkt_ready = w_pkt_ready;
   assign bus.pl_ready  = w_pl_ready;
   assign bus.wr_en     = w_wr_en;
   assign bus.data_out  = w_data_out;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.pkt_sent  = r_pkt_sent;
   assign bus.seq_num   = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_injector.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_noc_flit_injector                                   |
// | Description : Directed scenarios for the flit injector (NODE_ID=2).  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_noc_flit_injector;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   full_viol = 0;
   logic [31:0] wr_log [$];

   noc_flit_injector_if #(.FLIT_WIDTH(32)) bus ();

   noc_flit_injector #(
      .FLIT_WIDTH (32),
      .NODE_ID    (2),
      .MAX_LEN    (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Every flit the router FIFO would take, captured mid-cycle
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         wr_log.push_back(bus.data_out);
         if (bus.fifo_full !== 1'b0) full_viol++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd0; bus.pkt_len = 8'd0;
      bus.pl_valid = 1'b1;  bus.pl_data = 30'h0; bus.fifo_full = 1'b0;
      tick();
      #1;
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
      total++; if (bus.pkt_ready !== 1'b0) begin bad++; $display("FAIL rst_pkt_ready: got %b want 0", bus.pkt_ready); end
      total++; if (bus.pl_ready !== 1'b0) begin bad++; $display("FAIL rst_pl_ready: got %b want 0", bus.pl_ready); end
      tick();
      reset = 1'b0; bus.pkt_valid = 1'b0; bus.pl_valid = 1'b0;
      #1;
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL post_rst_wr_en: got %b want 0", bus.wr_en); end
      total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL post_rst_data: got %h want 00000000", bus.data_out); end
      total++; if (bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL post_rst_pkt_ready: got %b want 1", bus.pkt_ready); end
      total++; if (bus.seq_num !== 14'd0) begin bad++; $display("FAIL post_rst_seq: got %0d want 0", bus.seq_num); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", bus.busy); end
      total++; if (bus.pkt_sent !== 1'b0) begin bad++; $display("FAIL post_rst_pkt_sent: got %b want 0", bus.pkt_sent); end
   endtask

   task automatic test_single;
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd1; bus.pkt_len = 8'd0;
      #1;
      total++; if (bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.pkt_ready); end
      tick();
      bus.pkt_valid = 1'b0;
      #1;
      total++; if (bus.data_out !== 32'hC480_0000) begin bad++; $display("FAIL single_flit: got %h want C4800000", bus.data_out); end
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en: got %b want 1", bus.wr_en); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      total++; if (bus.pkt_ready !== 1'b0) begin bad++; $display("FAIL single_ready_busy: got %b want 0", bus.pkt_ready); end
      tick();
      #1;
      total++; if (bus.pkt_sent !== 1'b1) begin bad++; $display("FAIL single_sent: got %b want 1", bus.pkt_sent); end
      total++; if (bus.seq_num !== 14'd1) begin bad++; $display("FAIL single_seq: got %0d want 1", bus.seq_num); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", bus.busy); end
   endtask

   // Starts in the IDLE cycle that carries the previous pkt_sent pulse
   task automatic test_back_to_back;
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd3; bus.pkt_len = 8'd2;
      bus.pl_valid = 1'b1;  bus.pl_data = 30'h1000;
      #1;
      total++; if (bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", bus.pkt_ready); end
      total++; if (bus.pl_ready !== 1'b0) begin bad++; $display("FAIL b2b_pl_ready_idle: got %b want 0", bus.pl_ready); end
      tick();
      bus.pkt_valid = 1'b0;
      #1;
      total++; if (bus.data_out !== 32'h4C80_8001) begin bad++; $display("FAIL b2b_head: got %h want 4C808001", bus.data_out); end
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL b2b_head_wr: got %b want 1", bus.wr_en); end
      total++; if (bus.pl_ready !== 1'b0) begin bad++; $display("FAIL b2b_pl_ready_head: got %b want 0", bus.pl_ready); end
      tick();
      #1;
      total++; if (bus.data_out !== 32'h0000_1000) begin bad++; $display("FAIL b2b_body: got %h want 00001000", bus.data_out); end
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL b2b_body_wr: got %b want 1", bus.wr_en); end
      total++; if (bus.pl_ready !== 1'b1) begin bad++; $display("FAIL b2b_pl_ready: got %b want 1", bus.pl_ready); end
      tick();
      bus.pl_data = 30'h1001;
      #1;
      total++; if (bus.data_out !== 32'h8000_1001) begin bad++; $display("FAIL b2b_tail: got %h want 80001001", bus.data_out); end
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL b2b_tail_wr: got %b want 1", bus.wr_en); end
      tick();
      bus.pl_valid = 1'b0;
      #1;
      total++; if (bus.pkt_sent !== 1'b1) begin bad++; $display("FAIL b2b_sent: got %b want 1", bus.pkt_sent); end
      total++; if (bus.seq_num !== 14'd2) begin bad++; $display("FAIL b2b_seq: got %0d want 2", bus.seq_num); end
   endtask

   task automatic test_stall;
      wr_log.delete();
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd3; bus.pkt_len = 8'd2;
      bus.pl_valid = 1'b1;  bus.pl_data = 30'h1000;
      tick();
      bus.pkt_valid = 1'b0; bus.fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL stall_head_wr[%0d]: got %b want 0", k, bus.wr_en); end
         total++; if (bus.data_out !== 32'h4C80_8002) begin bad++; $display("FAIL stall_head_hold[%0d]: got %h want 4C808002", k, bus.data_out); end
         tick();
      end
      bus.fifo_full = 1'b0;
      #1;
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL stall_head_release: got %b want 1", bus.wr_en); end
      tick();
      bus.fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL stall_pl_wr[%0d]: got %b want 0", k, bus.wr_en); end
         total++; if (bus.pl_ready !== 1'b0) begin bad++; $display("FAIL stall_pl_ready[%0d]: got %b want 0", k, bus.pl_ready); end
         tick();
      end
      bus.fifo_full = 1'b0;
      #1;
      total++; if (bus.pl_ready !== 1'b1) begin bad++; $display("FAIL stall_pl_release: got %b want 1", bus.pl_ready); end
      tick();
      bus.pl_data = 30'h1001;
      tick();
      bus.pl_valid = 1'b0;
      #1;
      total++; if (bus.pkt_sent !== 1'b1) begin bad++; $display("FAIL stall_sent: got %b want 1", bus.pkt_sent); end
      total++; if (wr_log.size() !== 3) begin bad++; $display("FAIL stall_count: got %0d want 3", wr_log.size()); end
      if (wr_log.size() == 3) begin
         total++; if (wr_log[0] !== 32'h4C80_8002) begin bad++; $display("FAIL stall_seq0: got %h want 4C808002", wr_log[0]); end
         total++; if (wr_log[1] !== 32'h0000_1000) begin bad++; $display("FAIL stall_seq1: got %h want 00001000", wr_log[1]); end
         total++; if (wr_log[2] !== 32'h8000_1001) begin bad++; $display("FAIL stall_seq2: got %h want 80001001", wr_log[2]); end
      end
   endtask

   task automatic test_clamp;
      logic [31:0] exp;
      wr_log.delete();
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd5; bus.pkt_len = 8'd20;
      tick();
      bus.pkt_valid = 1'b0;
      #1;
      total++; if (bus.data_out !== 32'h5484_0003) begin bad++; $display("FAIL clamp_head: got %h want 54840003", bus.data_out); end
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL clamp_head_wr: got %b want 1", bus.wr_en); end
      tick();
      for (int i = 0; i < 16; i++) begin
         if ((i % 5) == 2) begin
            bus.pl_valid = 1'b0;
            repeat (2) begin
               #1;
               total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL clamp_gap_wr[%0d]: got %b want 0", i, bus.wr_en); end
               total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL clamp_gap_busy[%0d]: got %b want 1", i, bus.busy); end
               tick();
            end
         end
         bus.pl_valid = 1'b1;
         bus.pl_data  = 30'(32'h2000 + 32'(i));
         exp = 32'h2000 + 32'(i);
         if (i == 15) exp[31:30] = 2'b10;
         #1;
         total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL clamp_wr[%0d]: got %b want 1", i, bus.wr_en); end
         total++; if (bus.data_out !== exp) begin bad++; $display("FAIL clamp_flit[%0d]: got %h want %h", i, bus.data_out, exp); end
         tick();
      end
      bus.pl_valid = 1'b0;
      #1;
      total++; if (bus.pkt_sent !== 1'b1) begin bad++; $display("FAIL clamp_sent: got %b want 1", bus.pkt_sent); end
      total++; if (bus.seq_num !== 14'd4) begin bad++; $display("FAIL clamp_seq: got %0d want 4", bus.seq_num); end
      total++; if (wr_log.size() !== 17) begin bad++; $display("FAIL clamp_count: got %0d want 17", wr_log.size()); end
   endtask

   task automatic test_reset_mid;
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd2; bus.pkt_len = 8'd4;
      tick();
      bus.pkt_valid = 1'b0; bus.pl_valid = 1'b1; bus.pl_data = 30'h3000;
      #1;
      total++; if (bus.data_out !== 32'h4881_0004) begin bad++; $display("FAIL mid_head: got %h want 48810004", bus.data_out); end
      tick();
      reset = 1'b1;
      #1;
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr: got %b want 0", bus.wr_en); end
      total++; if (bus.pl_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_pl_ready: got %b want 0", bus.pl_ready); end
      tick();
      reset = 1'b0; bus.pl_valid = 1'b0;
      #1;
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL mid_after_wr: got %b want 0", bus.wr_en); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy: got %b want 0", bus.busy); end
      total++; if (bus.seq_num !== 14'd0) begin bad++; $display("FAIL mid_after_seq: got %0d want 0", bus.seq_num); end
      total++; if (bus.pkt_ready !== 1'b1) begin bad++; $display("FAIL mid_after_ready: got %b want 1", bus.pkt_ready); end
      wr_log.delete();
      bus.pkt_valid = 1'b1; bus.pkt_dest = 4'd7; bus.pkt_len = 8'd0;
      tick();
      bus.pkt_valid = 1'b0;
      #1;
      total++; if (bus.data_out !== 32'hDC80_0000) begin bad++; $display("FAIL mid_next_head: got %h want DC800000", bus.data_out); end
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL mid_next_wr: got %b want 1", bus.wr_en); end
      tick();
      #1;
      total++; if (bus.seq_num !== 14'd1) begin bad++; $display("FAIL mid_next_seq: got %0d want 1", bus.seq_num); end
      total++; if (wr_log.size() !== 1) begin bad++; $display("FAIL mid_next_count: got %0d want 1", wr_log.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_clamp();
      test_reset_mid();
      total++; if (full_viol !== 0) begin bad++; $display("FAIL write_while_full: got %0d want 0", full_viol); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
